hardwired_control_unit: RTL
===========================

# hardwired_control_unit

Sequencer that drives every control input of `ALUSystem`, replacing bench-applied control vectors with a fetch/decode/execute state machine. It sits directly upstream of `ALUSystem`: it consumes `IR_Out` and `ALU_FlagOut` and emits the full control word each cycle. Instructions are 16 bits, fetched as two bytes from memory at PC, and run a small four-instruction ISA plus HALT.

## Interface
- `Clock` in 1: single clock; all state changes on rising edge.
- `Reset` in 1: synchronous, active-high.
- `IR_Out` in 16: instruction register contents.
- `ALU_FlagOut` in 4: {Z,C,N,O}; bit 3 = Z.
- `RF_O1Sel`, `RF_O2Sel` out 3; `RF_FunSel` out 2; `RF_RSel`, `RF_TSel` out 4; `ALU_FunSel` out 4.
- `ARF_OutASel`, `ARF_OutBSel`, `ARF_FunSel` out 2; `ARF_RSel` out 4.
- `IR_LH`, `IR_Enable` out 1; `IR_Funsel` out 2; `Mem_WR`, `Mem_CS` out 1; `MuxASel`, `MuxBSel` out 2; `MuxCSel` out 1.
- `Halted` out 1: high in HALT state.
- `SeqT` out 2: current state encoding.

## Operation
- Encodings: FunSel 00 dec, 01 inc, 10 load, 11 clear; RSel/ARF_RSel are write masks, 0000 = hold; ARF_RSel bit0 = PC, bit1 = AR, bit2 = SP; ARF_OutBSel 10 = PC; Mem_CS=0 enables, Mem_WR=0 reads; MuxA/MuxB 00 ALUOut, 01 MemOut, 10 IR[7:0], 11 ARF_OutA; ALU_FunSel 0000 pass A, 0100 A+B.
- Idle word, driven whenever no action is listed: all RSel/TSel 0000, IR_Enable 0, Mem_CS 1, Mem_WR 0, other fields 0.
- States: FETCH_L (00) → FETCH_H (01) → EXEC (10) → FETCH_L; HALT (11) is absorbing until Reset.
- FETCH_L: ARF_OutBSel=10, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=10; ARF_RSel=0001, ARF_FunSel=01 (PC+1).
- FETCH_H: same as FETCH_L with IR_LH=1.
- EXEC decodes opcode IR_Out[15:12], Rd = IR_Out[11:10], Rs = IR_Out[9:8]. Register select = {1'b0, field}; RSel mask = 4'b1000 >> field.
  - 0 LDI: MuxASel=10, RF_FunSel=10, RSel(Rd).
  - 1 ADD: O1Sel=Rd, O2Sel=Rs, ALU_FunSel=0100, MuxASel=00, RF_FunSel=10, RSel(Rd). Rd ← Rd+Rs mod 256.
  - 2 INC: RF_FunSel=01, RSel(Rd).
  - 3 BNE: if ALU_FlagOut[3]==0, MuxBSel=10, ARF_FunSel=10, ARF_RSel=0001 (PC ← IR[7:0]); else idle word.
  - F HALT: idle word; next state HALT.
  - Others: idle word (NOP).
- Outputs are combinational from state, IR_Out and Z; all writes take effect at the closing rising edge.

## Timing
- Three cycles per instruction; HALT is entered after its EXEC cycle.
- While Reset is high: idle word on all outputs, regardless of state. At the first edge with Reset high, state becomes FETCH_L.
- Reset asserted mid-instruction aborts the instruction: no partial write occurs in that cycle.
- Reset outputs: SeqT=00, Halted=0.
- PC wraps 8'hFF→8'h00; this is ALUSystem behaviour and is not checked here.
- BNE samples Z during EXEC only. Z produced by the same instruction's flags is not visible.
- No handshake: ALUSystem is assumed to complete every control word in one cycle.

## Structure
- Package `cu_pkg`: state enum, opcode constants, FunSel/Mux/ALU encodings, and the idle control-word constant.
- One sub-module, `cu_decoder`: combinational (state, IR, Z) → control word. The top level holds only the state register and Reset gating.
- Integration top `cpu_top` instantiates `hardwired_control_unit` and `ALUSystem`.

## Test plan
- Reset held 3 cycles, then released: idle word throughout reset; SeqT sequence 00, 01, 10; PC=0 after reset.
- Memory {0x05, 0x00} (LDI R1,#5): after 3 cycles R1=5 and PC=2.
- Program LDI R1,#5; LDI R2,#3; ADD R1,R2: R1=8 after 9 cycles.
- LDI R1,#0 then ADD R1,R1 (sets Z=1) then BNE 0x00: branch not taken, PC=6. Same with #1: PC=0.
- HALT (0xF000) at address 2: Halted=1 from cycle 7 onward; PC stays at 4 indefinitely; idle word on all outputs.
- Reset asserted during FETCH_H: IR high byte unchanged and PC not incremented; fetch restarts in FETCH_L.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the hardwired control unit that sequences ALUSystem.
package cu_pkg;

    typedef enum logic [1:0] {
        FETCH_L = 2'b00,
        FETCH_H = 2'b01,
        EXEC    = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_BNE  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] FS_DEC   = 2'b00;
    localparam logic [1:0] FS_INC   = 2'b01;
    localparam logic [1:0] FS_LOAD  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b11;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IRLO = 2'b10;
    localparam logic [1:0] MUX_ARFA = 2'b11;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0100;

    localparam logic [1:0] ARF_OUT_PC = 2'b10;
    localparam logic [3:0] ARF_SEL_PC = 4'b0001;

    typedef struct packed {
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [1:0] rf_funsel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_funsel;
        logic [1:0] arf_outasel;
        logic [1:0] arf_outbsel;
        logic [1:0] arf_funsel;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxasel;
        logic [1:0] muxbsel;
        logic       muxcsel;
    } ctrl_t;

    // No register writes, memory deselected (Mem_CS is active-low).
    localparam ctrl_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

    function automatic logic [3:0] rsel_mask(input logic [1:0] field);
        return 4'b1000 >> field;
    endfunction

endpackage

// File: rtl/hardwired_control_unit_if.sv
// Control word and status lines between the control unit (master) and ALUSystem (slave).
interface hardwired_control_unit_if;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_FlagOut;
    logic [2:0]  RF_O1Sel;
    logic [2:0]  RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic        Halted;
    logic [1:0]  SeqT;

    modport master (
        input  IR_Out, ALU_FlagOut,
        output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, SeqT
    );

    modport slave (
        output IR_Out, ALU_FlagOut,
        input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, Halted, SeqT
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational decode of (state, instruction, Z flag) into the ALUSystem control word.
module cu_decoder
    import cu_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        z,
    output ctrl_t       ctrl
);
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;

    assign opcode = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];

    always_comb begin
        // NOTE: every field gets the idle default first so no path can infer a latch.
        ctrl = CTRL_IDLE;
        unique case (state)
            FETCH_L, FETCH_H: begin
                ctrl.arf_outbsel = ARF_OUT_PC;
                ctrl.mem_cs      = 1'b0;
                ctrl.ir_enable   = 1'b1;
                ctrl.ir_lh       = (state == FETCH_H);
                ctrl.ir_funsel   = FS_LOAD;
                ctrl.arf_rsel    = ARF_SEL_PC;
                ctrl.arf_funsel  = FS_INC;
            end
            EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        ctrl.muxasel   = MUX_IRLO;
                        ctrl.rf_funsel = FS_LOAD;
                        ctrl.rf_rsel   = rsel_mask(rd);
                    end
                    OP_ADD: begin
                        ctrl.rf_o1sel   = {1'b0, rd};
                        ctrl.rf_o2sel   = {1'b0, rs};
                        ctrl.alu_funsel = ALU_ADD;
                        ctrl.muxasel    = MUX_ALU;
                        ctrl.rf_funsel  = FS_LOAD;
                        ctrl.rf_rsel    = rsel_mask(rd);
                    end
                    OP_INC: begin
                        ctrl.rf_funsel = FS_INC;
                        ctrl.rf_rsel   = rsel_mask(rd);
                    end
                    OP_BNE: begin
                        if (!z) begin
                            ctrl.muxbsel    = MUX_IRLO;
                            ctrl.arf_funsel = FS_LOAD;
                            ctrl.arf_rsel   = ARF_SEL_PC;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/hardwired_control_unit.sv
// Fetch/decode/execute sequencer: holds the state register and gates the control word with Reset.
module hardwired_control_unit
    import cu_pkg::*;
(
    input logic                       Clock,
    input logic                       Reset,
    hardwired_control_unit_if.master  bus
);
    state_t state;
    state_t next_state;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    cu_decoder u_decoder (
        .state (state),
        .ir    (bus.IR_Out),
        .z     (bus.ALU_FlagOut[3]),
        .ctrl  (dec_ctrl)
    );

    // NOTE: sequential state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge Clock) begin
        if (Reset) state <= FETCH_L;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctrl       = dec_ctrl;
        unique case (state)
            FETCH_L: next_state = FETCH_H;
            FETCH_H: next_state = EXEC;
            EXEC:    next_state = (bus.IR_Out[15:12] == OP_HALT) ? HALT : FETCH_L;
            HALT:    next_state = HALT;
            default: next_state = FETCH_L;
        endcase
        // Reset masks the word so an interrupted instruction never writes anything.
        if (Reset) ctrl = CTRL_IDLE;
    end

    assign bus.RF_O1Sel    = ctrl.rf_o1sel;
    assign bus.RF_O2Sel    = ctrl.rf_o2sel;
    assign bus.RF_FunSel   = ctrl.rf_funsel;
    assign bus.RF_RSel     = ctrl.rf_rsel;
    assign bus.RF_TSel     = ctrl.rf_tsel;
    assign bus.ALU_FunSel  = ctrl.alu_funsel;
    assign bus.ARF_OutASel = ctrl.arf_outasel;
    assign bus.ARF_OutBSel = ctrl.arf_outbsel;
    assign bus.ARF_FunSel  = ctrl.arf_funsel;
    assign bus.ARF_RSel    = ctrl.arf_rsel;
    assign bus.IR_LH       = ctrl.ir_lh;
    assign bus.IR_Enable   = ctrl.ir_enable;
    assign bus.IR_Funsel   = ctrl.ir_funsel;
    assign bus.Mem_WR      = ctrl.mem_wr;
    assign bus.Mem_CS      = ctrl.mem_cs;
    assign bus.MuxASel     = ctrl.muxasel;
    assign bus.MuxBSel     = ctrl.muxbsel;
    assign bus.MuxCSel     = ctrl.muxcsel;
    assign bus.Halted      = !Reset && (state == HALT);
    assign bus.SeqT        = Reset ? 2'b00 : state;
endmodule
